// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache miss engines.
// Each grant is a LINE_WORDS-beat line burst; D-side wins ties, bounded by a starvation guard.
module mem_port_arbiter #(
  parameter int LINE_WORDS   = 8,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_wready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant
);

  localparam int BEAT_W   = $clog2(LINE_WORDS);
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state, state_next;
  logic [1:0]           grant_next;
  logic [31:0]          base, base_next;
  logic                 we, we_next;
  logic [BEAT_W-1:0]    beat, beat_next;
  logic [STREAK_W-1:0]  d_streak, d_streak_next;

  logic in_burst, beat_ack, last_beat, pick_i, pick_d;

  // I wins only when D is absent or D has used up its streak allowance.
  assign pick_i    = i_req & (~d_req | (d_streak == STREAK_MAX));
  assign pick_d    = d_req & ~pick_i;
  assign in_burst  = (state == BURST);
  assign beat_ack  = in_burst & mem_ack;
  assign last_beat = (beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 2'b00;
      base     <= '0;
      we       <= 1'b0;
      beat     <= '0;
      d_streak <= '0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      base     <= base_next;
      we       <= we_next;
      beat     <= beat_next;
      d_streak <= d_streak_next;
    end
  end

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    base_next     = base;
    we_next       = we;
    beat_next     = beat;
    d_streak_next = d_streak;
    case (state)
      IDLE: begin
        if (pick_i) begin
          state_next    = BURST;
          grant_next    = 2'b01;
          base_next     = i_addr & LINE_MASK;
          we_next       = 1'b0;
          beat_next     = '0;
          d_streak_next = '0;
        end else if (pick_d) begin
          state_next    = BURST;
          grant_next    = 2'b10;
          base_next     = d_addr & LINE_MASK;
          we_next       = d_we;
          beat_next     = '0;
          d_streak_next = i_req ? d_streak + STREAK_W'(1) : '0;
        end
      end
      BURST: begin
        if (mem_ack) begin
          beat_next = beat + BEAT_W'(1);
          if (last_beat) begin
            state_next = IDLE;
            grant_next = 2'b00;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req   = in_burst;
  assign mem_we    = in_burst & we;
  assign mem_addr  = in_burst ? base + 32'({beat, 2'b00}) : 32'd0;
  assign mem_wdata = in_burst ? d_wdata : 32'd0;

  // Beat handshakes are combinational on mem_ack so refill data arrives with zero latency.
  assign i_rvalid = beat_ack & grant[0];
  assign i_rdata  = i_rvalid ? mem_rdata : 32'd0;
  assign i_done   = i_rvalid & last_beat;
  assign d_rvalid = beat_ack & grant[1] & ~we;
  assign d_wready = beat_ack & grant[1] & we;
  assign d_rdata  = d_rvalid ? mem_rdata : 32'd0;
  assign d_done   = beat_ack & grant[1] & last_beat;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a directed vector table, hand-written corner
// sequences and a randomized phase, all checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LINE_WORDS   = 8;
  localparam int MAX_D_STREAK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_rvalid, i_done, d_wready, d_rvalid, d_done, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LINE_WORDS(LINE_WORDS), .MAX_D_STREAK(MAX_D_STREAK)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .grant(grant)
  );

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;

  // Transaction-level view of the port: who owns it, where the line starts, beats finished.
  bit          m_busy = 0;
  int          m_owner = 0;
  bit          m_we = 0;
  logic [31:0] m_base = 32'd0;
  int          m_beats = 0;
  int          m_streak = 0;

  bit         saw_i_done, saw_d_done;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] grant_log[$];
  int         grant_cycle_log[$];
  int         d_done_cycle = -1;
  int         cnt_d_wready, cnt_d_rvalid, cnt_d_done, cnt_i_rvalid, cnt_i_done;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        mem_ack;
    logic [1:0]  e_grant;
    logic        e_mem_req;
    logic [31:0] e_mem_addr;
    logic        e_i_rvalid;
    logic        e_i_done;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle_no);
    end
  endtask

  task automatic clear_counters();
    cnt_d_wready = 0; cnt_d_rvalid = 0; cnt_d_done = 0; cnt_i_rvalid = 0; cnt_i_done = 0;
    grant_log.delete();
    grant_cycle_log.delete();
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_we = 0; m_base = 32'd0; m_beats = 0; m_streak = 0;
  endtask

  task automatic model_grant(input int owner, input bit wr, input logic [31:0] addr);
    m_busy  = 1;
    m_owner = owner;
    m_we    = wr;
    m_base  = addr - (addr % 32'(LINE_WORDS * 4));
    m_beats = 0;
  endtask

  task automatic model_update(input bit r, input bit ir, input bit dr, input bit dwe,
                              input bit ack, input logic [31:0] ia, input logic [31:0] da);
    if (r) model_reset();
    else if (!m_busy) begin
      if (ir && dr) begin
        if (m_streak >= MAX_D_STREAK) begin model_grant(1, 0, ia); m_streak = 0; end
        else begin model_grant(2, dwe, da); m_streak++; end
      end else if (dr) begin
        model_grant(2, dwe, da); m_streak = 0;
      end else if (ir) begin
        model_grant(1, 0, ia); m_streak = 0;
      end
    end else if (ack) begin
      m_beats++;
      if (m_beats == LINE_WORDS) begin m_busy = 0; m_owner = 0; m_beats = 0; end
    end
  endtask

  task automatic compare_model();
    bit ack, last, oi, od;
    logic [1:0] eg;
    ack  = m_busy && (mem_ack === 1'b1);
    last = (m_beats == LINE_WORDS - 1);
    oi   = ack && (m_owner == 1);
    od   = ack && (m_owner == 2);
    eg   = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    checkOutput("grant", 32'(grant), 32'(eg));
    checkOutput("mem_ctrl", {30'd0, mem_req, mem_we}, {30'd0, m_busy, m_busy && m_we});
    checkOutput("mem_addr", mem_addr, m_busy ? m_base + 32'(m_beats * 4) : 32'd0);
    checkOutput("mem_wdata", mem_wdata, m_busy ? d_wdata : 32'd0);
    checkOutput("i_flags", {30'd0, i_rvalid, i_done}, {30'd0, oi, oi && last});
    checkOutput("i_rdata", i_rdata, oi ? mem_rdata : 32'd0);
    checkOutput("d_flags", {29'd0, d_rvalid, d_wready, d_done},
                {29'd0, od && !m_we, od && m_we, od && last});
    checkOutput("d_rdata", d_rdata, (od && !m_we) ? mem_rdata : 32'd0);
  endtask

  task automatic settle_and_check();
    d_wdata   = $urandom;
    mem_rdata = $urandom;
    #1;
    compare_model();
    saw_i_done = (i_done === 1'b1);
    saw_d_done = (d_done === 1'b1);
    cnt_d_wready += int'(d_wready === 1'b1);
    cnt_d_rvalid += int'(d_rvalid === 1'b1);
    cnt_d_done   += int'(saw_d_done);
    cnt_i_rvalid += int'(i_rvalid === 1'b1);
    cnt_i_done   += int'(saw_i_done);
    if (saw_d_done) d_done_cycle = cycle_no;
    if (grant !== prev_grant && grant !== 2'b00) begin
      grant_log.push_back(grant);
      grant_cycle_log.push_back(cycle_no);
    end
    prev_grant = grant;
  endtask

  task automatic advance_clock();
    bit r, ir, dr, dwe, ack;
    logic [31:0] ia, da;
    r = rst; ir = i_req; dr = d_req; dwe = d_we; ack = mem_ack; ia = i_addr; da = d_addr;
    @(posedge clk);
    model_update(r, ir, dr, dwe, ack, ia, da);
    cycle_no++;
    @(negedge clk);
  endtask

  task automatic applyStimulus();
    settle_and_check();
    advance_clock();
  endtask

  task automatic drive_idle();
    rst = 0; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0; i_addr = 32'd0; d_addr = 32'd0;
  endtask

  initial begin
    logic [1:0] exp_order[10];
    bit pend_i, pend_d;
    int n;

    drive_idle();
    rst = 1; d_wdata = 32'd0; mem_rdata = 32'd0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    model_reset();

    // Reset state: outputs all zero while rst is held with requests present.
    i_req = 1; d_req = 1; mem_ack = 1;
    applyStimulus();
    drive_idle();
    applyStimulus();

    // I-only refill, ack every cycle; row 0 is the arbitration cycle, rows 1..8 the beats.
    for (int k = 0; k < 10; k++) begin
      vecs[k].i_req      = (k < 9);
      vecs[k].i_addr     = 32'h0000_1014;
      vecs[k].d_req      = 1'b0;
      vecs[k].mem_ack    = (k < 9);
      vecs[k].e_grant    = (k >= 1 && k <= 8) ? 2'b01 : 2'b00;
      vecs[k].e_mem_req  = (k >= 1 && k <= 8);
      vecs[k].e_mem_addr = (k >= 1 && k <= 8) ? 32'h0000_1000 + 32'((k - 1) * 4) : 32'd0;
      vecs[k].e_i_rvalid = (k >= 1 && k <= 8);
      vecs[k].e_i_done   = (k == 8);
    end
    for (int k = 0; k < 10; k++) begin
      i_req = vecs[k].i_req; i_addr = vecs[k].i_addr; d_req = vecs[k].d_req;
      mem_ack = vecs[k].mem_ack;
      settle_and_check();
      checkOutput($sformatf("vec%0d_grant", k), 32'(grant), 32'(vecs[k].e_grant));
      checkOutput($sformatf("vec%0d_mem_req", k), 32'(mem_req), 32'(vecs[k].e_mem_req));
      checkOutput($sformatf("vec%0d_mem_addr", k), mem_addr, vecs[k].e_mem_addr);
      checkOutput($sformatf("vec%0d_i_rvalid", k), 32'(i_rvalid), 32'(vecs[k].e_i_rvalid));
      checkOutput($sformatf("vec%0d_i_done", k), 32'(i_done), 32'(vecs[k].e_i_done));
      advance_clock();
    end

    // D writeback with an ack on every second cycle.
    drive_idle(); clear_counters();
    d_req = 1; d_we = 1; d_addr = 32'h0000_2000;
    n = 0;
    do begin
      mem_ack = n[0];
      applyStimulus();
      n++;
    end while (!saw_d_done && n < 60);
    checkOutput("wb_done_in_time", 32'(saw_d_done), 32'd1);
    checkOutput("wb_wready_count", 32'(cnt_d_wready), 32'd8);
    checkOutput("wb_done_count", 32'(cnt_d_done), 32'd1);
    drive_idle();
    applyStimulus();

    // Simultaneous requests: D first, I one IDLE cycle after d_done.
    clear_counters();
    i_addr = 32'h0000_1100; d_addr = 32'h0000_2240; d_we = 0; mem_ack = 1;
    pend_i = 1; pend_d = 1; n = 0;
    while ((pend_i || pend_d) && n < 60) begin
      i_req = pend_i; d_req = pend_d;
      applyStimulus();
      if (saw_i_done) pend_i = 0;
      if (saw_d_done) pend_d = 0;
      n++;
    end
    checkOutput("both_grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      checkOutput("both_first_grant", 32'(grant_log[0]), 32'(2'b10));
      checkOutput("both_second_grant", 32'(grant_log[1]), 32'(2'b01));
      checkOutput("both_gap", 32'(grant_cycle_log[1] - d_done_cycle), 32'd2);
    end
    drive_idle();
    applyStimulus();

    // Starvation guard with both sides requesting continuously.
    rst = 1; applyStimulus(); rst = 0;
    clear_counters();
    exp_order = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    i_req = 1; d_req = 1; i_addr = 32'h0000_4004; d_addr = 32'h0000_5008; mem_ack = 1;
    n = 0;
    while (grant_log.size() < 10 && n < 250) begin
      d_we = $urandom_range(0, 1);
      applyStimulus();
      n++;
    end
    checkOutput("streak_grant_count", 32'(grant_log.size()), 32'd10);
    for (int k = 0; k < 10; k++)
      if (k < grant_log.size())
        checkOutput($sformatf("streak_order%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));
    drive_idle();
    n = 0;
    while (grant !== 2'b00 && n < 20) begin mem_ack = 1; applyStimulus(); n++; end
    drive_idle();
    applyStimulus();

    // Reset at beat 3 of a D refill abandons the burst without a done pulse.
    clear_counters();
    d_req = 1; d_we = 0; d_addr = 32'h0000_3044; mem_ack = 1;
    for (int k = 0; k < 4; k++) applyStimulus();
    rst = 1;
    applyStimulus();
    rst = 0; d_req = 0;
    settle_and_check();
    checkOutput("rst_mid_ctrl", {23'd0, mem_req, mem_we, grant, i_rvalid, i_done, d_rvalid,
                d_wready, d_done}, 32'd0);
    checkOutput("rst_mid_addr", mem_addr | d_rdata | i_rdata | mem_wdata, 32'd0);
    advance_clock();
    checkOutput("rst_mid_no_done", 32'(cnt_d_done), 32'd0);
    d_req = 1; d_addr = 32'h0000_3080;
    applyStimulus();
    settle_and_check();
    checkOutput("rst_fresh_grant", 32'(grant), 32'(2'b10));
    advance_clock();
    n = 0;
    while (!saw_d_done && n < 20) begin applyStimulus(); n++; end
    checkOutput("rst_fresh_done", 32'(cnt_d_done), 32'd1);
    drive_idle();
    applyStimulus();

    // d_req dropped at beat 2: burst still completes with a done pulse.
    clear_counters();
    d_req = 1; d_we = 0; d_addr = 32'h0000_6010; mem_ack = 1;
    for (int k = 0; k < 3; k++) applyStimulus();
    d_req = 0;
    n = 0;
    while (!saw_d_done && n < 20) begin applyStimulus(); n++; end
    checkOutput("drop_rvalid_count", 32'(cnt_d_rvalid), 32'd8);
    checkOutput("drop_done_count", 32'(cnt_d_done), 32'd1);
    applyStimulus();
    checkOutput("drop_back_idle", 32'(grant), 32'(2'b00));

    // Randomized traffic with well-behaved requesters and occasional resets.
    drive_idle();
    pend_i = 0; pend_d = 0;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!pend_i && $urandom_range(0, 99) < 30) begin pend_i = 1; i_addr = $urandom; end
      if (!pend_d && $urandom_range(0, 99) < 30) begin
        pend_d = 1; d_addr = $urandom; d_we = $urandom_range(0, 1);
      end
      i_req = pend_i; d_req = pend_d;
      mem_ack = ($urandom_range(0, 99) < 60);
      applyStimulus();
      if (saw_i_done || rst) pend_i = 0;
      if (saw_d_done || rst) pend_d = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
